// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO.
// Sizing functions and parameter sanity checks used at elaboration.
package fifo_pkg;

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit af_ok(input int depth, input int af);
        return (af >= 1) && (af <= depth);
    endfunction

    function automatic bit ae_ok(input int depth, input int ae);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised synchronous FIFO using all DEPTH slots, with occupancy,
// threshold flags, error pulses and optional first-word-fall-through read.
module sync_fifo_p
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 32,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    if (DATA_W < 1) begin : g_chk_width
        $error("sync_fifo_p: DATA_W must be >= 1");
    end
    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("sync_fifo_p: DEPTH must be a power of two >= 2");
    end
    if (!af_ok(DEPTH, AF_LEVEL)) begin : g_chk_af
        $error("sync_fifo_p: AF_LEVEL out of range 1..DEPTH");
    end
    if (!ae_ok(DEPTH, AE_LEVEL)) begin : g_chk_ae
        $error("sync_fifo_p: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] rd_data;
    logic              push_acc;
    logic              pop_acc;

    // Flags come straight from the registered count, so they are exact.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign push_acc = push & ~full;
    assign pop_acc  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) wptr <= wptr + 1'b1;
            if (pop_acc)  rptr <= rptr + 1'b1;
            if (push_acc && !pop_acc) begin
                count <= count + 1'b1;
            end else if (pop_acc && !push_acc) begin
                count <= count - 1'b1;
            end
            overflow  <= push & full;
            underflow <= pop & empty;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wptr),
        .wdata (push_data),
        .raddr (rptr),
        .rdata (rd_data)
    );

    if (FWFT != 0) begin : g_fwft
        assign pop_data = rd_data;
    end else begin : g_std
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pop_data <= '0;
            end else if (pop_acc) begin
                pop_data <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_p.sv
// Bench for sync_fifo_p: standard and FWFT instances share stimulus
// and are compared against a queue-based reference model.
module tb_sync_fifo_p;

    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] push_data;
    logic          pop;

    logic [DW-1:0] s_pd, f_pd;
    logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
    logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
    logic [5:0]    s_cnt, f_cnt;

    always #5 clk = ~clk;

    sync_fifo_p #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) u_std (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(s_pd), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
        .overflow(s_ov), .underflow(s_un)
    );

    sync_fifo_p #(
        .DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data),
        .pop(pop), .pop_data(f_pd), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
        .overflow(f_ov), .underflow(f_un)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, plus the last popped word.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_pd;
    logic          m_ov;
    logic          m_un;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pd = '0;
        m_ov = 1'b0;
        m_un = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic [DW-1:0] d,
                              input logic r);
        bit was_full, was_empty;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        m_ov = p && was_full;
        m_un = r && was_empty;
        if (r && !was_empty) m_pd = m_q.pop_front();
        if (p && !was_full)  m_q.push_back(d);
    endtask

    task automatic check_all();
        int n;
        n = m_q.size();
        chk("count",     32'(s_cnt),   32'(n));
        chk("empty",     32'(s_empty), 32'(n == 0));
        chk("full",      32'(s_full),  32'(n == DEPTH));
        chk("alm_full",  32'(s_af),    32'(n >= AF));
        chk("alm_empty", 32'(s_ae),    32'(n <= AE));
        chk("overflow",  32'(s_ov),    32'(m_ov));
        chk("underflow", 32'(s_un),    32'(m_un));
        chk("pop_data",  32'(s_pd),    32'(m_pd));
        chk("f_count",   32'(f_cnt),   32'(n));
        chk("f_ovf_unf", {30'd0, f_ov, f_un}, {30'd0, m_ov, m_un});
        chk("f_flags", {28'd0, f_full, f_empty, f_af, f_ae},
            {28'd0, n == DEPTH, n == 0, n >= AF, n <= AE});
        if (n > 0) chk("f_pop_data", 32'(f_pd), 32'(m_q[0]));
    endtask

    task automatic step(input logic p, input logic [DW-1:0] d,
                        input logic r);
        push      = p;
        push_data = d;
        pop       = r;
        @(posedge clk);
        model_edge(p, d, r);
        #1;
        check_all();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(s_cnt), 32'd0);
        chk({tag, "_flags"}, {26'd0, s_empty, s_ae, s_full, s_af, s_ov, s_un},
            {26'd0, 6'b110000});
        chk({tag, "_pd"}, 32'(s_pd), 32'd0);
        chk({tag, "_fcount"}, 32'(f_cnt), 32'd0);
    endtask

    typedef struct {
        logic          p;
        logic [DW-1:0] d;
        logic          r;
        int            cnt;
        logic          emp;
        logic          un;
        logic [DW-1:0] pd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h11};
        tbl[3] = '{1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b0, 8'h22};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h33};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h33};
        tbl[6] = '{1'b1, 8'h44, 1'b1, 1, 1'b0, 1'b1, 8'h33};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 8'h33};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h44};

        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        push_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        repeat (2) step(1'b0, 8'h00, 1'b0);

        foreach (tbl[i]) begin
            step(tbl[i].p, tbl[i].d, tbl[i].r);
            chk("vec_count", 32'(s_cnt), 32'(tbl[i].cnt));
            chk("vec_empty", 32'(s_empty), 32'(tbl[i].emp));
            chk("vec_unf", 32'(s_un), 32'(tbl[i].un));
            chk("vec_pd", 32'(s_pd), 32'(tbl[i].pd));
        end

        // FWFT: word visible right after the push edge, no pop needed.
        step(1'b1, 8'h5A, 1'b0);
        chk("fwft_5a", 32'(f_pd), 32'h5A);
        step(1'b0, 8'h00, 1'b1);

        // Fill to full, overflow, full push+pop, then drain.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == AF - 1) chk("af_rise", 32'(s_af), 32'd1);
            if (i == AF - 2) chk("af_below", 32'(s_af), 32'd0);
            if (i == AE)     chk("ae_fall", 32'(s_ae), 32'd0);
        end
        chk("full_cnt", 32'(s_cnt), 32'd32);
        step(1'b1, 8'hAA, 1'b0);
        chk("ovf_pulse", 32'(s_ov), 32'd1);
        step(1'b0, 8'h00, 1'b0);
        chk("ovf_clear", 32'(s_ov), 32'd0);
        step(1'b1, 8'hBB, 1'b1);
        chk("full_pp_cnt", 32'(s_cnt), 32'd31);
        chk("full_pp_pd", 32'(s_pd), 32'h00);
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_pd", 32'(s_pd), 32'(i));
            if (i == 4) chk("af_fall", 32'(s_af), 32'd0);
        end
        chk("drain_empty", 32'(s_empty), 32'd1);
        step(1'b0, 8'h00, 1'b1);
        chk("unf_hold", 32'(s_pd), 32'h1F);

        // Pointer wrap at constant occupancy of 3.
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
        end
        chk("wrap_cnt", 32'(s_cnt), 32'd3);

        // Asynchronous reset in the middle of a fill.
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
        chk("mid_cnt5", 32'(s_cnt), 32'd5);
        step(1'b0, 8'h00, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();

        // Randomised phases: fill-biased, drain-biased, balanced.
        for (int ph = 0; ph < 3; ph++) begin
            int pb, rb;
            pb = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
            rb = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 800; i++) begin
                step(1'($urandom_range(0, 99) < pb), 8'($urandom),
                     1'($urandom_range(0, 99) < rb));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
